// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and load/store requesters.
// One access at a time, round-robin on ties, fixed read latency.
module mem_port_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [63:0] IAddr,
    output logic        IGnt,
    output logic        IValid,
    output logic [31:0] IData,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [63:0] DAddr,
    input  logic [63:0] DWData,
    output logic        DGnt,
    output logic        DValid,
    output logic [63:0] DRData,
    output logic [63:0] MemAddr,
    output logic        MemWr,
    output logic [63:0] MemWData,
    input  logic [63:0] MemRData,
    output logic        Busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        last_d, last_d_n;
    logic        own_d, own_d_n;
    logic        wr_op, wr_op_n;
    logic        pick_d;
    logic        ignt_n, dgnt_n, ivalid_n, dvalid_n, memwr_n;
    logic [31:0] idata_n;
    logic [63:0] drdata_n, memaddr_n, memwdata_n;

    assign Busy = (state == BUSY);

    // last_d remembers who won most recently; ties go to the other one
    assign pick_d = DReq && (!IReq || !last_d);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_d_n   = last_d;
        own_d_n    = own_d;
        wr_op_n    = wr_op;
        ignt_n     = 1'b0;
        dgnt_n     = 1'b0;
        ivalid_n   = 1'b0;
        dvalid_n   = 1'b0;
        memwr_n    = 1'b0;
        idata_n    = IData;
        drdata_n   = DRData;
        memaddr_n  = MemAddr;
        memwdata_n = MemWData;
        unique case (state)
            IDLE: begin
                if (IReq || DReq) begin
                    state_n   = BUSY;
                    cnt_n     = LAT4;
                    last_d_n  = pick_d;
                    own_d_n   = pick_d;
                    wr_op_n   = pick_d && DWe;
                    memwr_n   = pick_d && DWe;
                    ignt_n    = !pick_d;
                    dgnt_n    = pick_d;
                    memaddr_n = pick_d ? DAddr : IAddr;
                    if (pick_d)
                        memwdata_n = DWData;
                end
            end
            BUSY: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = IDLE;
                    if (own_d) begin
                        dvalid_n = 1'b1;
                        if (!wr_op)
                            drdata_n = MemRData;
                    end else begin
                        ivalid_n = 1'b1;
                        idata_n  = MemRData[31:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last_d   <= 1'b0;
            own_d    <= 1'b0;
            wr_op    <= 1'b0;
            IGnt     <= 1'b0;
            DGnt     <= 1'b0;
            IValid   <= 1'b0;
            DValid   <= 1'b0;
            MemWr    <= 1'b0;
            IData    <= 32'd0;
            DRData   <= 64'd0;
            MemAddr  <= 64'd0;
            MemWData <= 64'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_d   <= last_d_n;
            own_d    <= own_d_n;
            wr_op    <= wr_op_n;
            IGnt     <= ignt_n;
            DGnt     <= dgnt_n;
            IValid   <= ivalid_n;
            DValid   <= dvalid_n;
            MemWr    <= memwr_n;
            IData    <= idata_n;
            DRData   <= drdata_n;
            MemAddr  <= memaddr_n;
            MemWData <= memwdata_n;
        end
    end

endmodule
